// File: rtl/decode_regfile_pkg.sv
// Shared definitions for the decode-stage register file and its pending-write scoreboard.
// Register addresses are MIPS-style 5-bit fields; $0 is hardwired to zero.
package decode_regfile_pkg;

    localparam int ADDR_W = 5;

    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
    localparam logic [ADDR_W-1:0] REG_RA   = 5'h1f;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_NREGS  = 32;
    localparam int DEF_CNT_W  = 2;

    // True when an enabled port targets a real (non-$0) register matching addr.
    function automatic logic port_hit(input logic              en,
                                      input logic [ADDR_W-1:0] port_addr,
                                      input logic [ADDR_W-1:0] addr);
        return en && (port_addr != REG_ZERO) && (port_addr == addr);
    endfunction

endpackage

// File: rtl/decode_regfile_reg_scoreboard.sv
// Per-register pending-write counters: incremented on issue, decremented on writeback.
// Reports source hazards, destination saturation and a sticky underflow error.
module reg_scoreboard
    import decode_regfile_pkg::*;
#(
    parameter int NREGS = DEF_NREGS,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              issue_fire_i,
    input  logic              issue_rwe_i,
    input  logic [ADDR_W-1:0] issue_d_i,
    input  logic              wb_rwe_i,
    input  logic [ADDR_W-1:0] wb_d_i,
    input  logic [ADDR_W-1:0] rs_addr_i,
    input  logic [ADDR_W-1:0] rt_addr_i,
    output logic              rs_busy_o,
    output logic              rt_busy_o,
    output logic              dst_sat_o,
    output logic              sb_err_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q [NREGS];
    logic [CNT_W-1:0] cnt_d [NREGS];
    logic             sb_err_q;
    logic             sb_err_d;
    logic             inc;
    logic             dec;
    logic [CNT_W-1:0] rs_eff;
    logic [CNT_W-1:0] rt_eff;

    assign inc = issue_fire_i && issue_rwe_i && (issue_d_i != REG_ZERO);
    assign dec = wb_rwe_i && (wb_d_i != REG_ZERO);

    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (port_hit(inc, issue_d_i, ADDR_W'(i)) && !port_hit(dec, wb_d_i, ADDR_W'(i))) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end else if (port_hit(dec, wb_d_i, ADDR_W'(i)) && !port_hit(inc, issue_d_i, ADDR_W'(i))
                         && (cnt_q[i] != '0)) begin
                cnt_d[i] = cnt_q[i] - 1'b1;
            end
        end
        sb_err_d = sb_err_q | (dec && (cnt_q[wb_d_i] == '0));
    end

    // The value retiring this cycle is bypassed, so it no longer counts as pending.
    assign rs_eff = cnt_q[rs_addr_i] - CNT_W'(port_hit(dec, wb_d_i, rs_addr_i));
    assign rt_eff = cnt_q[rt_addr_i] - CNT_W'(port_hit(dec, wb_d_i, rt_addr_i));

    assign rs_busy_o = (rs_addr_i != REG_ZERO) && (rs_eff != '0);
    assign rt_busy_o = (rt_addr_i != REG_ZERO) && (rt_eff != '0);
    assign dst_sat_o = issue_rwe_i && (issue_d_i != REG_ZERO) && (cnt_q[issue_d_i] == CNT_MAX);
    assign sb_err_o  = sb_err_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NREGS; i++) begin
                cnt_q[i] <= '0;
            end
            sb_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            sb_err_q <= sb_err_d;
        end
    end

endmodule

// File: rtl/decode_regfile.sv
// Decode-stage register file: write-first bypassed read ports, writeback sink,
// and the stall decision built from the pending-write scoreboard.
module decode_regfile
    import decode_regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NREGS  = DEF_NREGS,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic              rs_used,
    input  logic              rt_used,
    input  logic              issue_valid,
    input  logic              issue_rwe,
    input  logic [ADDR_W-1:0] issue_d,
    output logic [DATA_W-1:0] rsval,
    output logic [DATA_W-1:0] rtval,
    output logic              stall,
    input  logic              wb_rwe,
    input  logic [ADDR_W-1:0] wb_d,
    input  logic [DATA_W-1:0] wb_rdval,
    output logic              sb_err
);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic              wb_we;
    logic              issue_fire;
    logic              rs_busy;
    logic              rt_busy;
    logic              dst_sat;

    assign wb_we = wb_rwe && (wb_d != REG_ZERO);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_we) begin
            regs_q[wb_d] <= wb_rdval;
        end
    end

    assign rsval = (rs_addr == REG_ZERO)         ? '0       :
                   port_hit(wb_rwe, wb_d, rs_addr) ? wb_rdval : regs_q[rs_addr];
    assign rtval = (rt_addr == REG_ZERO)         ? '0       :
                   port_hit(wb_rwe, wb_d, rt_addr) ? wb_rdval : regs_q[rt_addr];

    assign stall = issue_valid && ((rs_used && rs_busy) || (rt_used && rt_busy) || dst_sat);
    assign issue_fire = issue_valid && !stall;

    reg_scoreboard #(
        .NREGS (NREGS),
        .CNT_W (CNT_W)
    ) u_scoreboard (
        .clk_i        (clock),
        .rst_n_i      (reset_n),
        .issue_fire_i (issue_fire),
        .issue_rwe_i  (issue_rwe),
        .issue_d_i    (issue_d),
        .wb_rwe_i     (wb_rwe),
        .wb_d_i       (wb_d),
        .rs_addr_i    (rs_addr),
        .rt_addr_i    (rt_addr),
        .rs_busy_o    (rs_busy),
        .rt_busy_o    (rt_busy),
        .dst_sat_o    (dst_sat),
        .sb_err_o     (sb_err)
    );

endmodule

// File: tb/tb_decode_regfile.sv
// Directed bench for decode_regfile: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_decode_regfile;
    import decode_regfile_pkg::*;

    logic        clock;
    logic        reset_n;
    logic [4:0]  rs_addr, rt_addr, issue_d, wb_d;
    logic        rs_used, rt_used, issue_valid, issue_rwe, wb_rwe;
    logic [31:0] wb_rdval;
    logic [31:0] rsval, rtval;
    logic        stall, sb_err;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        string       tag;
        bit          chk_rs;
        logic [31:0] rs;
        bit          chk_rt;
        logic [31:0] rt;
        logic        stall;
        logic        err;
    } exp_t;

    exp_t exp_q[$];

    decode_regfile dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .rs_addr     (rs_addr),
        .rt_addr     (rt_addr),
        .rs_used     (rs_used),
        .rt_used     (rt_used),
        .issue_valid (issue_valid),
        .issue_rwe   (issue_rwe),
        .issue_d     (issue_d),
        .rsval       (rsval),
        .rtval       (rtval),
        .stall       (stall),
        .wb_rwe      (wb_rwe),
        .wb_d        (wb_d),
        .wb_rdval    (wb_rdval),
        .sb_err      (sb_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drv(input logic iv, input logic irwe, input logic [4:0] id,
                       input logic rsu, input logic [4:0] rsa,
                       input logic rtu, input logic [4:0] rta,
                       input logic wbe, input logic [4:0] wbd, input logic [31:0] wbv);
        issue_valid = iv;
        issue_rwe   = irwe;
        issue_d     = id;
        rs_used     = rsu;
        rs_addr     = rsa;
        rt_used     = rtu;
        rt_addr     = rta;
        wb_rwe      = wbe;
        wb_d        = wbd;
        wb_rdval    = wbv;
    endtask

    task automatic chk(input string tag, input bit crs, input logic [31:0] rs,
                       input bit crt, input logic [31:0] rt, input logic st, input logic er);
        exp_t e;
        e.tag = tag; e.chk_rs = crs; e.rs = rs; e.chk_rt = crt; e.rt = rt;
        e.stall = st; e.err = er;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            while (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                if (e.chk_rs) begin
                    n_assert++;
                    if (rsval !== e.rs) begin
                        n_fail++;
                        $display("FAIL %s.rsval got=%h exp=%h", e.tag, rsval, e.rs);
                    end
                end
                if (e.chk_rt) begin
                    n_assert++;
                    if (rtval !== e.rt) begin
                        n_fail++;
                        $display("FAIL %s.rtval got=%h exp=%h", e.tag, rtval, e.rt);
                    end
                end
                n_assert++;
                if (stall !== e.stall) begin
                    n_fail++;
                    $display("FAIL %s.stall got=%b exp=%b", e.tag, stall, e.stall);
                end
                n_assert++;
                if (sb_err !== e.err) begin
                    n_fail++;
                    $display("FAIL %s.sb_err got=%b exp=%b", e.tag, sb_err, e.err);
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        reset_n = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        step();
        drv(1, 0, 0, 1, 5, 1, 0, 0, 0, 0);
        chk("in_reset", 1, 0, 1, 0, 0, 0);

        step();
        reset_n = 1'b1;
        chk("rd_zero", 1, 0, 1, 0, 0, 0);

        step(); drv(1, 1, 8, 0, 0, 0, 0, 0, 0, 0);
        chk("iss8", 0, 0, 0, 0, 0, 0);
        step(); drv(1, 0, 0, 1, 8, 0, 0, 0, 0, 0);
        chk("haz8", 1, 0, 0, 0, 1, 0);
        step(); drv(1, 0, 0, 1, 8, 0, 0, 1, 8, 32'hDEAD_BEEF);
        chk("byp8", 1, 32'hDEAD_BEEF, 0, 0, 0, 0);
        step(); drv(1, 0, 0, 1, 8, 0, 0, 0, 0, 0);
        chk("reg8", 1, 32'hDEAD_BEEF, 0, 0, 0, 0);

        step(); drv(1, 0, 0, 1, 0, 1, 8, 1, 0, 32'h0000_1234);
        chk("wb0", 1, 0, 1, 32'hDEAD_BEEF, 0, 0);
        step(); drv(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        chk("r0_after_wb0", 1, 0, 0, 0, 0, 0);

        step(); drv(1, 1, 9, 0, 0, 0, 0, 0, 0, 0);
        chk("iss9", 0, 0, 0, 0, 0, 0);
        step(); drv(1, 0, 0, 1, 0, 1, 9, 0, 0, 0);
        chk("haz9_rt", 1, 0, 1, 0, 1, 0);
        step(); drv(1, 0, 0, 1, 9, 1, 9, 1, 9, 32'hCAFE_0009);
        chk("wb9", 1, 32'hCAFE_0009, 1, 32'hCAFE_0009, 0, 0);
        step(); drv(1, 0, 0, 1, 9, 1, 9, 0, 0, 0);
        chk("reg9", 1, 32'hCAFE_0009, 1, 32'hCAFE_0009, 0, 0);

        for (int k = 0; k < 3; k++) begin
            step(); drv(1, 1, REG_RA, 0, 0, 0, 0, 0, 0, 0);
            chk("jal_fill", 0, 0, 0, 0, 0, 0);
        end
        step(); drv(1, 1, REG_RA, 0, 0, 0, 0, 0, 0, 0);
        chk("sat", 0, 0, 0, 0, 1, 0);
        step();
        chk("sat_hold", 0, 0, 0, 0, 1, 0);
        step(); drv(1, 1, REG_RA, 0, 0, 0, 0, 1, REG_RA, 32'h0000_0031);
        chk("sat_wb", 0, 0, 0, 0, 1, 0);
        step(); drv(1, 1, REG_RA, 0, 0, 0, 0, 1, REG_RA, 32'h0000_3131);
        chk("inc_dec_same", 0, 0, 0, 0, 0, 0);
        step(); drv(1, 1, REG_RA, 0, 0, 0, 0, 0, 0, 0);
        chk("refill", 0, 0, 0, 0, 0, 0);
        step();
        chk("resat", 0, 0, 0, 0, 1, 0);
        step(); drv(0, 1, REG_RA, 1, REG_RA, 0, 0, 0, 0, 0);
        chk("no_valid", 1, 32'h0000_3131, 0, 0, 0, 0);
        step(); drv(1, 0, 0, 1, REG_RA, 0, 0, 1, REG_RA, 32'h0000_0077);
        chk("eff31", 1, 32'h0000_0077, 0, 0, 1, 0);

        step(); drv(0, 0, 0, 1, 7, 0, 0, 1, 7, 32'h0000_0070);
        chk("wb7_zero_cnt", 1, 32'h0000_0070, 0, 0, 0, 0);
        step(); drv(0, 0, 0, 1, 7, 0, 0, 0, 0, 0);
        chk("err_set", 1, 32'h0000_0070, 0, 0, 0, 1);
        step();
        chk("err_sticky", 1, 32'h0000_0070, 0, 0, 0, 1);

        step();
        reset_n = 1'b0;
        drv(1, 1, REG_RA, 1, 7, 1, 8, 0, 0, 0);
        chk("async_rst", 1, 0, 1, 0, 0, 0);
        step();
        reset_n = 1'b1;
        drv(1, 0, 0, 1, REG_RA, 1, 9, 0, 0, 0);
        chk("post_rst", 1, 0, 1, 0, 0, 0);

        step(); drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clock);
        n_assert++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain pending=%0d exp=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
